// File: rtl/branch_predictor_if.sv
// Branch predictor bus: fetch-side lookup, resolved-branch update and
// misprediction reporting grouped into one interface.
// master = pipeline side (drives fetch/update), slave = predictor.
interface branch_predictor_if;
   logic [31:0] fetch_pc;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        predict_reset;
   logic        prediction;
   logic [31:0] pre_pc;
   logic        btb_hit;
   logic [15:0] miss_count;

   modport master (
      output fetch_pc,
      output update_valid,
      output update_pc,
      output update_taken,
      output update_target,
      output predict_reset,
      input  prediction,
      input  pre_pc,
      input  btb_hit,
      input  miss_count
   );

   modport slave (
      input  fetch_pc,
      input  update_valid,
      input  update_pc,
      input  update_taken,
      input  update_target,
      input  predict_reset,
      output prediction,
      output pre_pc,
      output btb_hit,
      output miss_count
   );
endinterface

// File: rtl/branch_predictor.sv
// Branch predictor: 32-entry direct-mapped BTB plus 32-entry table of
// 2-bit saturating counters, with a saturating misprediction counter.
// Lookup is purely combinational; updates land on the next rising clk,
// so a same-cycle lookup sees the pre-update contents (no bypass).
// Optional macro BRANCH_PREDICTOR_GSHARE_EN: adds a 5-bit global history
// register XORed into the counter-table index (BTB index unaffected).
// Reset is synchronous and active-low.
module branch_predictor (
   input  logic clk,
   input  logic reset_n,
   branch_predictor_if.slave bp
);

   localparam int ENTRIES = 32;

   // BTB storage: valid bits are reset, tags/targets are plain storage
   logic [ENTRIES-1:0] btb_valid;
   logic [24:0]        btb_tag    [ENTRIES];
   logic [31:0]        btb_target [ENTRIES];

   // Branch history table of 2-bit counters (00 strong NT .. 11 strong T)
   logic [1:0]         bht [ENTRIES];

   logic [15:0]        miss_count;

   logic [4:0]         lookup_btb_idx;
   logic [4:0]         update_btb_idx;
   logic [4:0]         lookup_bht_idx;
   logic [4:0]         update_bht_idx;

   logic               lookup_hit;
   logic               lookup_taken;

   // Word-alignment bits of the update PC carry no index or tag information
   logic [1:0]         unused_update_pc_bits;

   assign unused_update_pc_bits = bp.update_pc[1:0];

   // Saturating increment/decrement of a 2-bit direction counter
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                           input logic       taken);
      logic [1:0] result;
      result = ctr;
      if (taken) begin
         if (ctr != 2'b11) result = ctr + 2'b01;
      end else begin
         if (ctr != 2'b00) result = ctr - 2'b01;
      end
      return result;
   endfunction

   assign lookup_btb_idx = bp.fetch_pc[6:2];
   assign update_btb_idx = bp.update_pc[6:2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   // Global history: newest resolved outcome enters bit 0
   logic [4:0] ghr;

   // Shift history on every resolved branch; lookup and update both use
   // the value held before this edge's shift
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ghr <= 5'b00000;
      end else if (bp.update_valid) begin
         ghr <= {ghr[3:0], bp.update_taken};
      end
   end

   assign lookup_bht_idx = bp.fetch_pc[6:2]  ^ ghr;
   assign update_bht_idx = bp.update_pc[6:2] ^ ghr;
`else
   assign lookup_bht_idx = bp.fetch_pc[6:2];
   assign update_bht_idx = bp.update_pc[6:2];
`endif

   // Valid bits: cleared on reset, set by any taken update at that index
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         btb_valid <= '0;
      end else if (bp.update_valid && bp.update_taken) begin
         btb_valid[update_btb_idx] <= 1'b1;
      end
   end

   // Tag/target write on a taken update; an aliasing entry is simply replaced
   always_ff @(posedge clk) begin
      if (reset_n && bp.update_valid && bp.update_taken) begin
         btb_tag[update_btb_idx]    <= bp.update_pc[31:7];
         btb_target[update_btb_idx] <= bp.update_target;
      end
   end

   // Direction counters: reset to weakly not-taken, trained on every update
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (bp.update_valid) begin
         bht[update_bht_idx] <= ctr_next(bht[update_bht_idx], bp.update_taken);
      end
   end

   // Misprediction counter, sticks at all-ones rather than wrapping
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         miss_count <= 16'h0000;
      end else if (bp.predict_reset && (miss_count != 16'hFFFF)) begin
         miss_count <= miss_count + 16'h0001;
      end
   end

   // Combinational lookup: hit requires a valid entry with matching tag,
   // and a taken prediction additionally needs the counter MSB set
   always_comb begin
      lookup_hit   = 1'b0;
      lookup_taken = 1'b0;
      if (btb_valid[lookup_btb_idx] &&
          (btb_tag[lookup_btb_idx] == bp.fetch_pc[31:7])) begin
         lookup_hit = 1'b1;
      end
      if (lookup_hit && bht[lookup_bht_idx][1]) begin
         lookup_taken = 1'b1;
      end
   end

   assign bp.btb_hit    = lookup_hit;
   assign bp.prediction = lookup_taken;
   assign bp.pre_pc     = lookup_taken ? btb_target[lookup_btb_idx]
                                       : bp.fetch_pc + 32'd4;
   assign bp.miss_count = miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table,
// hand-written reset/saturation sequences and randomized traffic checked
// against a behavioural table model.
module tb_branch_predictor;

   logic clk = 1'b0;
   logic reset_n;

   int compared   = 0;
   int mismatched = 0;

   branch_predictor_if bus();

   branch_predictor dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bp      (bus)
   );

   always #5 clk = ~clk;

   // Bench-side copies of what is currently being driven
   bit        d_rn;
   bit [31:0] d_fetch;
   bit        d_uv;
   bit [31:0] d_upc;
   bit        d_ut;
   bit [31:0] d_utgt;
   bit        d_pr;

   // Behavioural model state
   bit        m_valid  [32];
   bit [31:0] m_tag    [32];
   bit [31:0] m_target [32];
   int        m_ctr    [32];
   int        m_miss;
   int        m_ghr;

   typedef struct {
      logic [31:0] fetch;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        pr;
      logic        exp_hit;
      logic        exp_pred;
      logic [31:0] exp_pc;
      logic [15:0] exp_miss;
   } vec_t;

   vec_t vecs [14];

   function automatic int btbIndex(input bit [31:0] pc);
      return int'((pc >> 2) % 32);
   endfunction

   function automatic int bhtIndex(input bit [31:0] pc);
      int i;
      i = int'((pc >> 2) % 32);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      i = i ^ m_ghr;
`endif
      return i;
   endfunction

   task automatic modelEdge();
      int b;
      int e;
      if (!d_rn) begin
         for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
         end
         m_miss = 0;
         m_ghr  = 0;
      end else begin
         if (d_pr && m_miss < 65535) m_miss = m_miss + 1;
         if (d_uv) begin
            b = bhtIndex(d_upc);
            e = btbIndex(d_upc);
            if (d_ut) begin
               if (m_ctr[b] < 3) m_ctr[b] = m_ctr[b] + 1;
               m_valid[e]  = 1'b1;
               m_tag[e]    = d_upc >> 7;
               m_target[e] = d_utgt;
            end else begin
               if (m_ctr[b] > 0) m_ctr[b] = m_ctr[b] - 1;
            end
            m_ghr = ((m_ghr << 1) | int'(d_ut)) % 32;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic applyStimulus(input bit [31:0] fetch, input bit rn,
                                input bit uv, input bit [31:0] upc,
                                input bit ut, input bit [31:0] utgt,
                                input bit pr);
      d_fetch = fetch; d_rn = rn; d_uv = uv; d_upc = upc;
      d_ut = ut; d_utgt = utgt; d_pr = pr;
      reset_n            = rn;
      bus.fetch_pc       = fetch;
      bus.update_valid   = uv;
      bus.update_pc      = upc;
      bus.update_taken   = ut;
      bus.update_target  = utgt;
      bus.predict_reset  = pr;
      #1;
   endtask

   task automatic compareVal(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Compare all outputs against the behavioural model for current inputs
   task automatic checkOutput(input string tag);
      int  e;
      int  b;
      bit  hit;
      bit  pred;
      bit [31:0] nxt;
      e    = btbIndex(d_fetch);
      b    = bhtIndex(d_fetch);
      hit  = m_valid[e] && (m_tag[e] == (d_fetch >> 7));
      pred = hit && (m_ctr[b] >= 2);
      nxt  = pred ? m_target[e] : d_fetch + 32'd4;
      compareVal({tag, ".btb_hit"},    {31'b0, bus.btb_hit},    {31'b0, hit});
      compareVal({tag, ".prediction"}, {31'b0, bus.prediction}, {31'b0, pred});
      compareVal({tag, ".pre_pc"},     bus.pre_pc,              nxt);
      compareVal({tag, ".miss_count"}, {16'b0, bus.miss_count},  m_miss[31:0]);
   endtask

   function automatic bit [31:0] pickPc();
      bit [24:0] tag;
      bit [4:0]  idx;
      if ($urandom_range(0, 19) == 0) return $urandom();
      case ($urandom_range(0, 3))
         0:       tag = 25'h0000000;
         1:       tag = 25'h0000001;
         2:       tag = 25'h0001234;
         default: tag = 25'h1FFFFFF;
      endcase
      idx = 5'($urandom_range(0, 31));
      return {tag, idx, 2'b00};
   endfunction

   task automatic initTable();
      vecs[0]  = '{32'h40,       1'b1, 32'h40,   1'b1, 32'h100,      1'b0, 1'b0, 1'b0, 32'h44,   16'd0};
      vecs[1]  = '{32'h40,       1'b1, 32'h40,   1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h100,  16'd0};
      vecs[2]  = '{32'h40,       1'b1, 32'h40,   1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44,   16'd0};
      vecs[3]  = '{32'h40,       1'b1, 32'h40,   1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44,   16'd0};
      vecs[4]  = '{32'h40,       1'b0, 32'h40,   1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h44,   16'd0};
      vecs[5]  = '{32'h40,       1'b1, 32'h40,   1'b1, 32'h100,      1'b0, 1'b1, 1'b0, 32'h44,   16'd1};
      vecs[6]  = '{32'h40,       1'b1, 32'h40,   1'b1, 32'h100,      1'b0, 1'b1, 1'b0, 32'h44,   16'd1};
      vecs[7]  = '{32'h40,       1'b1, 32'h1040, 1'b1, 32'h200,      1'b1, 1'b1, 1'b1, 32'h100,  16'd1};
      vecs[8]  = '{32'h40,       1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h44,   16'd2};
      vecs[9]  = '{32'h1040,     1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200,  16'd2};
      vecs[10] = '{32'hFFFFFFFC, 1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,    16'd2};
      vecs[11] = '{32'h1040,     1'b1, 32'h1040, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200,  16'd2};
      vecs[12] = '{32'h1040,     1'b1, 32'h1040, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200,  16'd2};
      vecs[13] = '{32'h1040,     1'b0, 32'h0,    1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h1044, 16'd2};
   endtask

   initial begin
      initTable();
      applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      tick();
      tick();

      // Reset state seen while reset is still asserted
      checkOutput("reset_hold");
      compareVal("reset_hold.pre_pc_const", bus.pre_pc, 32'h44);

      // Directed vectors: train, decay, alias and boundary wrap
      applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("after_reset");
`ifndef BRANCH_PREDICTOR_GSHARE_EN
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].fetch, 1'b1, vecs[i].uv, vecs[i].upc,
                       vecs[i].ut, vecs[i].utgt, vecs[i].pr);
         compareVal($sformatf("vec%0d.btb_hit", i),    {31'b0, bus.btb_hit},    {31'b0, vecs[i].exp_hit});
         compareVal($sformatf("vec%0d.prediction", i), {31'b0, bus.prediction}, {31'b0, vecs[i].exp_pred});
         compareVal($sformatf("vec%0d.pre_pc", i),     bus.pre_pc,              vecs[i].exp_pc);
         compareVal($sformatf("vec%0d.miss_count", i), {16'b0, bus.miss_count},  {16'b0, vecs[i].exp_miss});
         tick();
      end
`endif

      // Miss counter saturation over a long run of mispredictions
      applyStimulus(32'h1040, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 70000; i++) tick();
      compareVal("miss_saturate", {16'b0, bus.miss_count}, 32'h0000FFFF);
      checkOutput("miss_saturate_model");
      tick();
      compareVal("miss_stay_sat", {16'b0, bus.miss_count}, 32'h0000FFFF);

      // Reset wins over a simultaneous taken update and misprediction
      applyStimulus(32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
      tick();
      applyStimulus(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      compareVal("post_reset.miss", {16'b0, bus.miss_count}, 32'h0);
      compareVal("post_reset.hit40", {31'b0, bus.btb_hit}, 32'h0);
      compareVal("post_reset.pc40", bus.pre_pc, 32'h44);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(32'h1000 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         compareVal($sformatf("post_reset.hit_idx%0d", i), {31'b0, bus.btb_hit}, 32'h0);
      end

      // Randomized traffic against the behavioural model
      for (int n = 0; n < 3000; n++) begin
         bit [31:0] f;
         bit [31:0] u;
         bit        rn;
         f  = pickPc();
         u  = ($urandom_range(0, 2) == 0) ? f : pickPc();
         rn = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         applyStimulus(f, rn, 1'($urandom_range(0, 1)), u,
                       1'($urandom_range(0, 1)), $urandom(),
                       ($urandom_range(0, 4) == 0));
         checkOutput($sformatf("rand%0d", n));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 fetch_pc  input  32  PC of the instruction in fetch (lookup address).
REQ-005 update_valid  input  1  resolved branch present this cycle; enables table update.
REQ-006 update_pc  input  32  PC of the resolved branch.
REQ-007 update_taken  input  1  actual branch outcome (1 = taken).
REQ-008 update_target  input  32  actual branch target (cu_pc from the control unit).
REQ-009 predict_reset  input  1  misprediction flag from the correctness checker.
REQ-010 prediction  output  1  predicted direction for fetch_pc (1 = taken).
REQ-011 pre_pc  output  32  predicted next PC for fetch_pc.
REQ-012 btb_hit  output  1  fetch_pc hits a valid BTB entry.
REQ-013 miss_count  output  16  count of mispredictions since reset.

Function
REQ-014 The BTB SHALL hold 32 entries: valid (1), tag = pc[31:7] (25), target (32); BTB index = pc[6:2].
REQ-015 The BHT SHALL hold 32 two-bit saturating counters: 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T.
REQ-016 Lookup SHALL be combinational from fetch_pc: btb_hit = valid && tag match; prediction = btb_hit && counter[1].
REQ-017 pre_pc SHALL equal the BTB target when prediction = 1, otherwise fetch_pc + 4 (32-bit wrap, carry discarded).
REQ-018 On a rising clk with update_valid = 1, the BHT counter at the update index SHALL increment if update_taken = 1 and decrement if 0, saturating at 11 and 00.
REQ-019 On update_valid = 1 and update_taken = 1, the BTB entry at update_pc[6:2] SHALL be written with valid = 1, tag = update_pc[31:7], target = update_target; a tag-mismatched entry is replaced.
REQ-020 On update_valid = 1 and update_taken = 0, the BTB SHALL NOT be modified.
REQ-021 update_valid = 0 SHALL leave all tables unchanged; update_taken, update_pc, update_target are then ignored.
REQ-022 Lookup and update to the same index in one cycle SHALL return pre-update contents; the new value is visible from the next cycle (no bypass).
REQ-023 miss_count SHALL increment by 1 on each rising clk with predict_reset = 1, saturate at 16'hFFFF, and be unaffected by update_valid.
REQ-024 Update latency SHALL be one cycle: an update at edge N affects lookups from cycle N+1.

Reset
REQ-025 While reset_n = 0 at a rising clk: all BTB valid bits SHALL clear to 0, all BHT counters to 01, miss_count to 0, GHR (if present) to 0; tags and targets need not be cleared.
REQ-026 Reset SHALL override any simultaneous update_valid or predict_reset.
REQ-027 During and immediately after reset: btb_hit = 0, prediction = 0, pre_pc = fetch_pc + 4.

Configuration
REQ-028 The macro BRANCH_PREDICTOR_GSHARE_EN SHALL select the BHT indexing scheme.
REQ-029 Without the macro: BHT index = pc[6:2] for both lookup and update; no GHR exists.
REQ-030 With the macro: a 5-bit GHR SHALL exist; BHT index = pc[6:2] XOR GHR for both lookup and update, using the current (pre-shift) GHR.
REQ-031 With the macro, on update_valid = 1 the GHR SHALL shift left by 1 with update_taken entering bit 0; the BTB index stays pc[6:2].

Verification
REQ-032 Reset, then fetch_pc = 0x0000_0040 -> btb_hit = 0, prediction = 0, pre_pc = 0x0000_0044.
REQ-033 One update: pc 0x40, taken, target 0x100 -> next cycle fetch 0x40: btb_hit = 1, counter 10, prediction = 1, pre_pc = 0x100.
REQ-034 Then two not-taken updates at pc 0x40 -> counter 00, btb_hit = 1, prediction = 0, pre_pc = 0x44; a further not-taken update keeps counter 00.
REQ-035 Taken update at 0x40 (target 0x100), then taken update at 0x1040 (target 0x200) -> fetch 0x40 misses; fetch 0x1040 -> pre_pc = 0x200 (aliasing replacement).
REQ-036 predict_reset held for 70000 cycles -> miss_count = 0xFFFF; reset_n = 0 for one edge -> miss_count = 0, all btb_hit = 0.
REQ-037 fetch_pc = 0xFFFF_FFFC with no hit -> pre_pc = 0x0000_0000; with GSHARE_EN, after taken updates at pc 0x40 then 0x80, GHR = 00011.
